// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default unit count, unit index type and the
// one-hot to binary encoder used by the arbiter and the CDB mux.
package cdb_pkg;

   localparam int CDB_N_UNITS       = 4;
   localparam int CDB_IDX_WIDTH     = $clog2(CDB_N_UNITS);
   localparam int CDB_MAX_UNITS     = 16;
   localparam int CDB_MAX_IDX_WIDTH = 4;

   typedef logic [CDB_IDX_WIDTH-1:0] cdb_unit_idx_t;

   // OR-encode: exact for one-hot input, and all-zero input yields index 0.
   function automatic logic [CDB_MAX_IDX_WIDTH-1:0] onehot_to_idx(
      input logic [CDB_MAX_UNITS-1:0] onehot
   );
      logic [CDB_MAX_IDX_WIDTH-1:0] idx;
      idx = '0;
      for (int i = 0; i < CDB_MAX_UNITS; i++) begin
         if (onehot[i]) begin
            idx = idx | CDB_MAX_IDX_WIDTH'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: lowest request at or above the pointer,
// falling back to the lowest request overall when none sits above it.
module rr_priority_select #(
   parameter int N_UNITS   = 4,
   parameter int IDX_WIDTH = $clog2(N_UNITS)
) (
   input  logic [N_UNITS-1:0]   req_i,
   input  logic [IDX_WIDTH-1:0] ptr_i,
   output logic [N_UNITS-1:0]   grant_o
);

   logic [N_UNITS-1:0] mask;
   logic [N_UNITS-1:0] masked_req;
   logic [N_UNITS-1:0] masked_pick;
   logic [N_UNITS-1:0] unmasked_pick;

   genvar gi;
   generate
      for (gi = 0; gi < N_UNITS; gi++) begin : g_mask
         assign mask[gi] = (IDX_WIDTH'(gi) >= ptr_i);
      end
   endgenerate

   assign masked_req = req_i & mask;

   // x & -x isolates the lowest set bit.
   assign masked_pick   = masked_req & (~masked_req + N_UNITS'(1));
   assign unmasked_pick = req_i & (~req_i + N_UNITS'(1));

   assign grant_o = (|masked_req) ? masked_pick : unmasked_pick;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one-hot permit to at most one output buffer per cycle.
// Optional debug ports (pointer, grant counter) under CDB_ARBITER_DEBUG_EN.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int N_UNITS   = CDB_N_UNITS,
   parameter int IDX_WIDTH = $clog2(N_UNITS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_UNITS-1:0]   not_empty,
   input  logic                 cdb_stall,
   output logic [N_UNITS-1:0]   cdb_permit,
   output logic                 cdb_valid,
   output logic [IDX_WIDTH-1:0] grant_idx
`ifdef CDB_ARBITER_DEBUG_EN
   ,
   output logic [IDX_WIDTH-1:0] dbg_priority_ptr,
   output logic [31:0]          dbg_grant_count
`endif
);

   logic [IDX_WIDTH-1:0]         priority_ptr_q;
   logic [IDX_WIDTH-1:0]         priority_ptr_d;
   logic [N_UNITS-1:0]           req_gated;
   logic [N_UNITS-1:0]           grant;
   logic [CDB_MAX_IDX_WIDTH-1:0] idx_full;

   // A stall looks like an empty request vector, so the pointer holds too.
   assign req_gated = cdb_stall ? '0 : not_empty;

   rr_priority_select #(
      .N_UNITS   (N_UNITS),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_select (
      .req_i   (req_gated),
      .ptr_i   (priority_ptr_q),
      .grant_o (grant)
   );

   assign cdb_permit = grant;
   assign cdb_valid  = |grant;
   assign idx_full   = onehot_to_idx(CDB_MAX_UNITS'(grant));
   assign grant_idx  = IDX_WIDTH'(idx_full);

   always_comb begin
      priority_ptr_d = priority_ptr_q;
      if (cdb_valid) begin
         priority_ptr_d = (grant_idx == IDX_WIDTH'(N_UNITS - 1)) ? '0
                                                                 : grant_idx + IDX_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         priority_ptr_q <= '0;
      end else begin
         priority_ptr_q <= priority_ptr_d;
      end
   end

`ifdef CDB_ARBITER_DEBUG_EN
   logic [31:0] grant_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         grant_count_q <= '0;
      end else if (cdb_valid) begin
         grant_count_q <= grant_count_q + 32'd1;
      end
   end

   assign dbg_priority_ptr = priority_ptr_q;
   assign dbg_grant_count  = grant_count_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed walk through the arbitration
// cases, then random requests/stalls/resets checked against a search model.
module tb_cdb_arbiter;

   localparam int N = 4;

   logic         clk;
   logic         reset;
   logic [N-1:0] not_empty;
   logic         cdb_stall;
   logic [N-1:0] cdb_permit;
   logic         cdb_valid;
   logic [1:0]   grant_idx;
`ifdef CDB_ARBITER_DEBUG_EN
   logic [1:0]   dbg_priority_ptr;
   logic [31:0]  dbg_grant_count;
`endif

   cdb_arbiter #(
      .N_UNITS   (N),
      .IDX_WIDTH (2)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .not_empty        (not_empty),
      .cdb_stall        (cdb_stall),
      .cdb_permit       (cdb_permit),
      .cdb_valid        (cdb_valid),
      .grant_idx        (grant_idx)
`ifdef CDB_ARBITER_DEBUG_EN
      ,
      .dbg_priority_ptr (dbg_priority_ptr),
      .dbg_grant_count  (dbg_grant_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [N-1:0] permit;
      logic        valid;
      logic [1:0]  idx;
      logic [1:0]  ptr;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   // Reference state: which unit currently has top priority, and grants seen.
   int          m_ptr = 0;
   logic [31:0] m_cnt = '0;

   task automatic step(input string name, input logic [N-1:0] ne,
                       input logic st, input logic rs);
      exp_t e;
      int   g;
      @(posedge clk);
      #1;
      not_empty = ne;
      cdb_stall = st;
      reset     = rs;
      g = -1;
      if (!st) begin
         for (int k = 0; k < N; k++) begin
            int u;
            u = (m_ptr + k) % N;
            if (g < 0 && ne[u]) g = u;
         end
      end
      e.name   = name;
      e.permit = '0;
      if (g >= 0) e.permit[g] = 1'b1;
      e.valid  = (g >= 0);
      e.idx    = (g >= 0) ? 2'(g) : 2'd0;
      e.ptr    = 2'(m_ptr);
      e.cnt    = m_cnt;
      exp_q.push_back(e);
      if (rs) begin
         m_ptr = 0;
         m_cnt = '0;
      end else if (g >= 0) begin
         m_ptr = (g + 1) % N;
         m_cnt = m_cnt + 32'd1;
      end
   endtask

   // Monitor: outputs are combinational, so every cycle presents a result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (cdb_permit !== e.permit || cdb_valid !== e.valid || grant_idx !== e.idx) begin
               mismatched++;
               $display("FAIL %s: got permit=%b valid=%b idx=%0d, expected permit=%b valid=%b idx=%0d",
                        e.name, cdb_permit, cdb_valid, grant_idx, e.permit, e.valid, e.idx);
            end else begin
               $display("ok   %s: ne=%b stall=%b rst=%b permit=%b idx=%0d",
                        e.name, not_empty, cdb_stall, reset, cdb_permit, grant_idx);
            end
`ifdef CDB_ARBITER_DEBUG_EN
            compared++;
            if (dbg_priority_ptr !== e.ptr || dbg_grant_count !== e.cnt) begin
               mismatched++;
               $display("FAIL %s_dbg: got ptr=%0d count=%0d, expected ptr=%0d count=%0d",
                        e.name, dbg_priority_ptr, dbg_grant_count, e.ptr, e.cnt);
            end
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d expectations pending", exp_q.size());
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0] ne;
      int           s;
      reset     = 1'b1;
      not_empty = '0;
      cdb_stall = 1'b0;
      repeat (2) @(posedge clk);

      step("reset_idle", 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("rr_all", 4'b1111, 1'b0, 1'b0);
      step("to_ptr3", 4'b0100, 1'b0, 1'b0);
      step("wrap_search", 4'b0110, 1'b0, 1'b0);
      step("wrap_next", 4'b0110, 1'b0, 1'b0);
      step("stall", 4'b0100, 1'b1, 1'b0);
      step("stall", 4'b0100, 1'b1, 1'b0);
      step("unstall", 4'b0100, 1'b0, 1'b0);
      step("to_ptr2", 4'b0010, 1'b0, 1'b0);
      step("grant2", 4'b0100, 1'b0, 1'b0);
      step("reset_grant", 4'b1000, 1'b0, 1'b1);
      step("after_reset", 4'b1000, 1'b0, 1'b0);

      step("cnt_reset", 4'b0000, 1'b0, 1'b1);
      foreach (ne[i]) ne[i] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         // 7 grant cycles interleaved with 3 idle cycles
         ne = (i == 1 || i == 4 || i == 7) ? 4'b0000 : 4'b1011;
         step("cnt", ne, 1'b0, 1'b0);
      end
      step("cnt_final", 4'b0000, 1'b0, 1'b0);
      step("cnt_clear", 4'b0000, 1'b0, 1'b1);
      step("cnt_zero", 4'b0000, 1'b0, 1'b0);

      for (int i = 0; i < 300; i++) begin
         ne = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) begin
            s  = int'($urandom_range(0, 3));
            ne = '0;
            ne[s] = 1'b1;
         end
         step("rand", ne, ($urandom_range(0, 4) == 0), ($urandom_range(0, 39) == 0));
      end

      repeat (3) @(posedge clk);
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that grants the common data bus (CDB) to exactly one functional unit output buffer per cycle. Each buffer raises `not_empty`; the arbiter returns a one-hot `cdb_permit`, and the granted buffer drives `cdb_data`/`cdb_tag` in the same cycle and pops at the next rising edge. It sits between all functional unit output buffers and the CDB mux, and is the only source of `cdb_permit` in the out-of-order core.

## Interface
- `N_UNITS`, 4: number of requesting output buffers, 2..16.
- `IDX_WIDTH`, `$clog2(N_UNITS)`: width of unit indices.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `not_empty`  in  N_UNITS  per-unit request; bit i is buffer i's `not_empty`.
- `cdb_stall`  in  1  when high, no grant is issued this cycle.
- `cdb_permit`  out  N_UNITS  one-hot grant, or all zero; bit i drives buffer i's `cdb_permit`.
- `cdb_valid`  out  1  OR of `cdb_permit`; the CDB mux output is valid this cycle.
- `grant_idx`  out  IDX_WIDTH  binary index of the granted unit; 0 when `cdb_valid`=0.

## Operation
- State: `priority_ptr` (IDX_WIDTH). Unit `priority_ptr` has highest priority, then ascending with wrap-around modulo N_UNITS.
- Grant is combinational from `not_empty`, `cdb_stall`, `priority_ptr`: the first set request at or after `priority_ptr` (wrapping) is granted.
- `cdb_stall`=1 or `not_empty`=0: `cdb_permit`=0, `cdb_valid`=0, `grant_idx`=0, pointer holds.
- On a cycle with a grant to unit g: `priority_ptr` <= (g+1) mod N_UNITS at the next edge. When g = N_UNITS-1, the pointer wraps to 0.
- No grant: pointer unchanged.
- A unit with a continuously asserted request is granted at least once every N_UNITS grant cycles; no starvation.
- Exactly one request present: granted regardless of pointer position.
- The arbiter does not track buffer occupancy. A buffer that still holds data keeps `not_empty` high and competes again next cycle.
- `reset`=1: `priority_ptr` <= 0. Outputs are combinational and follow the inputs while reset is held. Reset overrides a pointer update in the same cycle.
- Request bits at or above N_UNITS do not exist. The pointer never takes a value ≥ N_UNITS.

## Timing
- Request-to-grant latency: 0 cycles. Grant follows `not_empty` combinationally within the cycle.
- The buffer pops at the edge that ends the grant cycle. The pointer advances at the same edge.
- Back-to-back grants to different units are possible every cycle. The same unit is granted on consecutive cycles only when it is the sole requester.
- After reset deassertion: all outputs 0 while `not_empty`=0; `priority_ptr`=0.

## Configuration
- `CDB_ARBITER_DEBUG_EN` defined: adds output `dbg_priority_ptr` (IDX_WIDTH) exposing the pointer. Also adds `dbg_grant_count` (32), a counter of granted cycles that is reset to 0 on `reset`, increments on each cycle with `cdb_valid`=1, and wraps at 2^32.
- Macro undefined: neither port nor counter exists. Grant behaviour is identical in both builds.

## Structure
- Shared package `cdb_pkg` holds:
  - the default `N_UNITS` constant;
  - `cdb_unit_idx_t` typedef (IDX_WIDTH logic);
  - a `onehot_to_idx` function used by the arbiter and the CDB mux.
- One sub-module, `rr_priority_select`:
  - purely combinational;
  - takes the request vector and the pointer;
  - returns the one-hot grant;
  - implemented as a masked/unmasked double fixed-priority pick.
- The top level holds the pointer register, stall gating, index encode and the debug logic.

## Test plan
- Reset, then `not_empty`=4'b0000 -> `cdb_permit`=0, `cdb_valid`=0, `grant_idx`=0, pointer 0.
- Pointer 0, `not_empty`=4'b1111 held for 5 cycles -> `grant_idx` sequence 0,1,2,3,0. `cdb_permit` sequence 0001,0010,0100,1000,0001.
- Pointer 3, `not_empty`=4'b0110 -> grant unit 1 (wrap search), pointer becomes 2. With the request unchanged, the next grant is unit 2.
- `not_empty`=4'b0100 with `cdb_stall`=1 for 2 cycles, then `cdb_stall`=0 -> no permit and pointer unchanged during the stall, then `cdb_permit`=0100, `grant_idx`=2.
- Grant unit 2 with pointer 2, then `reset` asserted next cycle with `not_empty`=4'b1000 -> pointer 0 after the edge. The following cycle grants unit 3, and the pointer becomes 0 (3+1 wraps).
- With `CDB_ARBITER_DEBUG_EN`: 7 grant cycles interleaved with 3 idle cycles -> `dbg_grant_count`=7. After `reset` it returns to 0.
